// File: rtl/sass_seq_pkg.sv
// Shared definitions for the step sequencer beat generator.
// Holds the FSM state type and the default build-time constants.
// Imported by sequencer_beat_gen.
package sass_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } seq_state_t;

    localparam int unsigned DEF_CNT_W     = 22;
    localparam int unsigned DEF_SUBDIV    = 4;
    localparam int unsigned DEF_BAR_STEPS = 16;

endpackage

// File: rtl/sequencer_beat_gen.sv
// Purpose: step/beat/bar pulse timebase for a step sequencer (tempo = step period - 1).
// Latency: all outputs registered; downbeat appears one cycle after start or restart.
// Backpressure: none; pause freezes the timebase and the interrupted step resumes where it stopped.
//
// Ports: clk, n_rst (async active-low); sequencer_on, pause, restart, tempo[CNT_W] in;
//        step_pulse, beat_pulse, bar_pulse, step_idx[STEP_W], running out.
module sequencer_beat_gen
    import sass_seq_pkg::*;
#(
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned SUBDIV    = DEF_SUBDIV,
    parameter int unsigned BAR_STEPS = DEF_BAR_STEPS,
    localparam int unsigned STEP_W   = $clog2(BAR_STEPS)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              sequencer_on,
    input  logic              pause,
    input  logic              restart,
    input  logic [CNT_W-1:0]  tempo,
    output logic              step_pulse,
    output logic              beat_pulse,
    output logic              bar_pulse,
    output logic [STEP_W-1:0] step_idx,
    output logic              running
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(BAR_STEPS - 1);

    seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [STEP_W-1:0] step_d;
    logic [STEP_W-1:0] nxt_step;
    logic              step_d_pulse, beat_d_pulse, bar_d_pulse;

    assign nxt_step = (step_idx == LAST_STEP) ? '0 : step_idx + STEP_W'(1);

    // Priority: off > restart > pause > terminal count.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        period_d     = period_q;
        step_d       = step_idx;
        step_d_pulse = 1'b0;
        beat_d_pulse = 1'b0;
        bar_d_pulse  = 1'b0;
        if (!sequencer_on) begin
            state_d  = ST_IDLE;
            count_d  = '0;
            period_d = '0;
            step_d   = '0;
        end else if (state_q == ST_IDLE || restart) begin
            // Start or restart: immediate downbeat at step 0.
            state_d      = ST_RUN;
            count_d      = '0;
            period_d     = tempo;
            step_d       = '0;
            step_d_pulse = 1'b1;
            beat_d_pulse = 1'b1;
            bar_d_pulse  = 1'b1;
        end else if (pause) begin
            // Everything holds, including a count already sitting at terminal.
            state_d = ST_PAUSED;
        end else begin
            // RUN, or the first resumed edge out of PAUSED, which counts normally.
            state_d = ST_RUN;
            if (count_q == period_q) begin
                count_d      = '0;
                period_d     = tempo;
                step_d       = nxt_step;
                step_d_pulse = 1'b1;
                beat_d_pulse = ((32'(nxt_step) % SUBDIV) == 32'd0);
                bar_d_pulse  = (nxt_step == '0);
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            period_q   <= '0;
            step_idx   <= '0;
            step_pulse <= 1'b0;
            beat_pulse <= 1'b0;
            bar_pulse  <= 1'b0;
            running    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            period_q   <= period_d;
            step_idx   <= step_d;
            step_pulse <= step_d_pulse;
            beat_pulse <= beat_d_pulse;
            bar_pulse  <= bar_d_pulse;
            running    <= (state_d == ST_RUN);
        end
    end

endmodule

// File: tb/tb_sequencer_beat_gen.sv
// Bench for sequencer_beat_gen: directed timing scenarios plus a randomized run
// checked cycle-by-cycle against a step-count reference model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_sequencer_beat_gen;

    localparam int CNT_W     = 22;
    localparam int SUBDIV    = 4;
    localparam int BAR_STEPS = 16;
    localparam int STEP_W    = 4;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              sequencer_on;
    logic              pause;
    logic              restart;
    logic [CNT_W-1:0]  tempo;
    logic              step_pulse;
    logic              beat_pulse;
    logic              bar_pulse;
    logic [STEP_W-1:0] step_idx;
    logic              running;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sequencer_beat_gen #(
        .CNT_W     (CNT_W),
        .SUBDIV    (SUBDIV),
        .BAR_STEPS (BAR_STEPS)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .sequencer_on (sequencer_on),
        .pause        (pause),
        .restart      (restart),
        .tempo        (tempo),
        .step_pulse   (step_pulse),
        .beat_pulse   (beat_pulse),
        .bar_pulse    (bar_pulse),
        .step_idx     (step_idx),
        .running      (running)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        sequencer_on = 1'b0;
        pause        = 1'b0;
        restart      = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        n_rst = 1'b0; sequencer_on = 1'b0; pause = 1'b0; restart = 1'b0; tempo = '0;
        #3;
        checks++;
        if ({step_pulse, beat_pulse, bar_pulse} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses got %b exp 000", {step_pulse, beat_pulse, bar_pulse});
        end
        checks++;
        if (step_idx !== 4'd0) begin
            errors++; $display("FAIL reset_step_idx got %0d exp 0", step_idx);
        end
        checks++;
        if (running !== 1'b0) begin
            errors++; $display("FAIL reset_running got %b exp 0", running);
        end
        tick();
        n_rst = 1'b1;
        tick();
        checks++;
        if ({step_pulse, running} !== 2'b00) begin
            errors++; $display("FAIL idle_after_reset got %b exp 00", {step_pulse, running});
        end
    endtask

    task automatic test_basic_timing();
        logic [2:0] exp_p;
        tempo = 22'd4;
        sequencer_on = 1'b1;
        for (int c = 1; c <= 90; c++) begin
            tick();
            exp_p = {((c - 1) % 5 == 0), ((c - 1) % 20 == 0), ((c - 1) % 80 == 0)};
            checks++;
            if ({step_pulse, beat_pulse, bar_pulse} !== exp_p) begin
                errors++; $display("FAIL basic_pulses cycle %0d got %b exp %b", c, {step_pulse, beat_pulse, bar_pulse}, exp_p);
            end
            if (c == 21) begin
                checks++;
                if (step_idx !== 4'd4) begin
                    errors++; $display("FAIL basic_step_idx_c21 got %0d exp 4", step_idx);
                end
            end
        end
        go_idle();
    endtask

    task automatic test_fast_tempo();
        logic [2:0] exp_p;
        tempo = 22'd0;
        sequencer_on = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            exp_p = {1'b1, ((c - 1) % 4 == 0), ((c - 1) % 16 == 0)};
            checks++;
            if ({step_pulse, beat_pulse, bar_pulse} !== exp_p) begin
                errors++; $display("FAIL fast_pulses cycle %0d got %b exp %b", c, {step_pulse, beat_pulse, bar_pulse}, exp_p);
            end
            checks++;
            if (int'(step_idx) !== (c - 1) % 16) begin
                errors++; $display("FAIL fast_step_idx cycle %0d got %0d exp %0d", c, step_idx, (c - 1) % 16);
            end
        end
        go_idle();
    endtask

    task automatic test_tempo_change();
        int pulses[$];
        int exp_t[4] = '{1, 6, 11, 21};
        tempo = 22'd4;
        sequencer_on = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (step_pulse === 1'b1) pulses.push_back(c);
            if (c == 8) tempo = 22'd9;
        end
        checks++;
        if (pulses.size() != 4) begin
            errors++; $display("FAIL tempo_chg_count got %0d exp 4", pulses.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (pulses[i] != exp_t[i]) begin
                    errors++; $display("FAIL tempo_chg_pulse%0d got cycle %0d exp %0d", i, pulses[i], exp_t[i]);
                end
            end
        end
        go_idle();
    endtask

    task automatic test_pause();
        int pulses[$];
        tempo = 22'd4;
        sequencer_on = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (step_pulse === 1'b1) pulses.push_back(c);
            if (c >= 4 && c <= 6) begin
                checks++;
                if ({running, step_idx} !== 5'd0) begin
                    errors++; $display("FAIL pause_hold cycle %0d got run=%b idx=%0d exp run=0 idx=0", c, running, step_idx);
                end
            end
            if (c == 7) begin
                checks++;
                if (running !== 1'b1) begin
                    errors++; $display("FAIL pause_resume_running got %b exp 1", running);
                end
            end
            if (c == 9) begin
                checks++;
                if (step_idx !== 4'd1) begin
                    errors++; $display("FAIL pause_step_idx got %0d exp 1", step_idx);
                end
            end
            if (c == 3) pause = 1'b1;
            if (c == 6) pause = 1'b0;
        end
        checks++;
        if (pulses.size() != 2 || pulses[0] != 1 || pulses[1] != 9) begin
            errors++; $display("FAIL pause_interval got %0d pulses last at %0d exp 2 pulses at 1,9",
                               pulses.size(), (pulses.size() > 0) ? pulses[pulses.size() - 1] : -1);
        end
        go_idle();
    endtask

    task automatic test_priority();
        tempo = 22'd4;
        sequencer_on = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 6) begin
                checks++;
                if ({step_pulse, step_idx} !== 5'b1_0001) begin
                    errors++; $display("FAIL prio_pre_step got p=%b idx=%0d exp p=1 idx=1", step_pulse, step_idx);
                end
            end
            if (c == 10) sequencer_on = 1'b0;
        end
        checks++;
        if ({step_pulse, beat_pulse, bar_pulse, running, step_idx} !== 8'd0) begin
            errors++; $display("FAIL prio_off_on_terminal got p=%b run=%b idx=%0d exp all 0", step_pulse, running, step_idx);
        end
        // restart while paused, pause still held
        tempo = 22'd0;
        sequencer_on = 1'b1;
        tick(); tick(); tick();
        pause = 1'b1;
        tick();
        checks++;
        if ({running, step_idx} !== 5'b0_0010) begin
            errors++; $display("FAIL prio_paused got run=%b idx=%0d exp run=0 idx=2", running, step_idx);
        end
        tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checks++;
        if ({step_pulse, beat_pulse, bar_pulse, running, step_idx} !== 8'b1111_0000) begin
            errors++; $display("FAIL prio_restart_paused got %b exp 11110000",
                               {step_pulse, beat_pulse, bar_pulse, running, step_idx});
        end
        tick();
        checks++;
        if ({step_pulse, running} !== 2'b00) begin
            errors++; $display("FAIL prio_repause got %b exp 00", {step_pulse, running});
        end
        go_idle();
    endtask

    task automatic test_async_reset();
        tempo = 22'd4;
        sequencer_on = 1'b1;
        repeat (7) tick();
        checks++;
        if ({running, step_idx} !== 5'b1_0001) begin
            errors++; $display("FAIL areset_pre got run=%b idx=%0d exp run=1 idx=1", running, step_idx);
        end
        #3;
        n_rst = 1'b0;
        #1;
        checks++;
        if ({step_pulse, beat_pulse, bar_pulse, running, step_idx} !== 8'd0) begin
            errors++; $display("FAIL areset_immediate got %b exp 0",
                               {step_pulse, beat_pulse, bar_pulse, running, step_idx});
        end
        tick(); tick();
        n_rst = 1'b1;
        tick();
        checks++;
        if ({step_pulse, beat_pulse, bar_pulse, running, step_idx} !== 8'b1111_0000) begin
            errors++; $display("FAIL areset_downbeat got %b exp 11110000",
                               {step_pulse, beat_pulse, bar_pulse, running, step_idx});
        end
        go_idle();
    endtask

    // Reference model: tracks the mode, cycles elapsed in the current step, the
    // latched step length and an unbounded step number; step_idx is step_no mod 16.
    task automatic test_random();
        int mode = 0;          // 0 off, 1 running, 2 paused
        int elapsed = 0;
        int len = 0;
        int step_no = 0;
        logic m_step, m_beat, m_bar;
        logic [7:0] exp_v;
        pause = 1'b0;
        tempo = 22'd3;
        for (int c = 0; c < 3000; c++) begin
            sequencer_on = ($urandom_range(0, 99) < 97);
            if ($urandom_range(0, 9) == 0) pause = ~pause;
            restart = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 9) == 0) tempo = 22'($urandom_range(0, 6));
            tick();
            m_step = 1'b0; m_beat = 1'b0; m_bar = 1'b0;
            if (!sequencer_on) begin
                mode = 0; step_no = 0; elapsed = 0; len = 0;
            end else if (mode == 0 || restart) begin
                mode = 1; step_no = 0; elapsed = 0; len = int'(tempo) + 1;
                m_step = 1'b1; m_beat = 1'b1; m_bar = 1'b1;
            end else if (pause) begin
                mode = 2;
            end else begin
                mode = 1;
                elapsed++;
                if (elapsed == len) begin
                    elapsed = 0;
                    step_no++;
                    len = int'(tempo) + 1;
                    m_step = 1'b1;
                    m_beat = (step_no % SUBDIV == 0);
                    m_bar  = (step_no % BAR_STEPS == 0);
                end
            end
            exp_v = {m_step, m_beat, m_bar, (mode == 1), 4'(step_no % BAR_STEPS)};
            checks++;
            if ({step_pulse, beat_pulse, bar_pulse, running, step_idx} !== exp_v) begin
                errors++; $display("FAIL random cycle %0d got %b exp %b", c,
                                   {step_pulse, beat_pulse, bar_pulse, running, step_idx}, exp_v);
            end
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_basic_timing();
        test_fast_tempo();
        test_tempo_change();
        test_pause();
        test_priority();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
